// File: rtl/spi_copy_sched.sv
// Arbitrates two flash-to-SPRAM copy requesters over one SPI read FIFO.
// Each copy writes exactly the latched word count, then drains FIFO prefetch.
module spi_copy_sched #(
  parameter int LEN_W      = 14,
  parameter int FLUSH_CYC  = 16,
  parameter int START_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_req,
  input  logic [23:0]      i_flash_addr0,
  input  logic [23:0]      i_flash_addr1,
  input  logic [LEN_W-1:0] i_spram_addr0,
  input  logic [LEN_W-1:0] i_spram_addr1,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic [1:0]       o_grant,
  output logic [1:0]       o_done,
  output logic             o_busy,
  output logic             o_fill,
  output logic [23:0]      o_flash_addr,
  input  logic             i_fifo_empty,
  input  logic             i_word_en,
  input  logic [31:0]      i_word,
  output logic             o_spram_we,
  output logic [LEN_W-1:0] o_spram_addr,
  output logic [31:0]      o_spram_wdata
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int IDLE_W = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic               rr_ptr_r, win_r, win_s, win_nx_s;
  logic               accept_s, idle_cyc_s, fill_nx_s, grant_nx_s;
  logic [23:0]        flash_addr_r, sel_flash_s;
  logic [LEN_W-1:0]   wptr_r, rem_r, sel_spram_s, sel_len_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [IDLE_W-1:0]  idle_cnt_r;

  // Arbitration winner, request operand select and next-state decode
  always_comb begin
    state_s = state_r;
    if (i_req[rr_ptr_r]) win_s = rr_ptr_r;
    else                 win_s = ~rr_ptr_r;
    if (state_r == S_IDLE) win_nx_s = win_s;
    else                   win_nx_s = win_r;
    sel_flash_s = win_r ? i_flash_addr1 : i_flash_addr0;
    sel_spram_s = win_r ? i_spram_addr1 : i_spram_addr0;
    sel_len_s   = win_r ? i_len1        : i_len0;
    accept_s    = (state_r == S_RUN) && i_word_en;
    idle_cyc_s  = i_fifo_empty && !i_word_en;
    case (state_r)
      S_IDLE: begin
        if (|i_req) state_s = S_GRANT;
        else        state_s = S_IDLE;
      end
      S_GRANT: begin
        if (sel_len_s == LEN_W'(0)) state_s = S_DONE;
        else                        state_s = S_START;
      end
      S_START: begin
        if (hold_cnt_r == HOLD_W'(START_HOLD - 1)) state_s = S_RUN;
        else                                       state_s = S_START;
      end
      S_RUN: begin
        if (accept_s && (rem_r == LEN_W'(1))) state_s = S_DRAIN;
        else                                  state_s = S_RUN;
      end
      S_DRAIN: begin
        if (idle_cyc_s && (idle_cnt_r == IDLE_W'(FLUSH_CYC - 1))) state_s = S_DONE;
        else                                                      state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    fill_nx_s  = (state_s == S_START) || (state_s == S_RUN);
    grant_nx_s = (state_s == S_GRANT) || fill_nx_s || (state_s == S_DRAIN);
  end

  // State, transfer bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      rr_ptr_r      <= 1'b0;
      win_r         <= 1'b0;
      flash_addr_r  <= 24'd0;
      wptr_r        <= LEN_W'(0);
      rem_r         <= LEN_W'(0);
      hold_cnt_r    <= HOLD_W'(0);
      idle_cnt_r    <= IDLE_W'(0);
      o_grant       <= 2'b00;
      o_done        <= 2'b00;
      o_busy        <= 1'b0;
      o_fill        <= 1'b0;
      o_flash_addr  <= 24'd0;
      o_spram_we    <= 1'b0;
      o_spram_addr  <= LEN_W'(0);
      o_spram_wdata <= 32'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_IDLE) && (|i_req)) begin
        win_r    <= win_s;
        rr_ptr_r <= ~win_s;
      end
      if (state_r == S_GRANT) begin
        flash_addr_r <= sel_flash_s;
        wptr_r       <= sel_spram_s;
        rem_r        <= sel_len_s;
        hold_cnt_r   <= HOLD_W'(0);
      end else if (state_r == S_START) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end
      // Words outside RUN (START overrun, DRAIN prefetch) never reach SPRAM
      if (accept_s) begin
        wptr_r <= wptr_r + LEN_W'(1);
        rem_r  <= rem_r - LEN_W'(1);
      end
      if ((state_r == S_DRAIN) && idle_cyc_s) idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      else                                    idle_cnt_r <= IDLE_W'(0);

      o_busy  <= (state_s != S_IDLE);
      o_fill  <= fill_nx_s;
      o_grant <= grant_nx_s ? {win_nx_s, ~win_nx_s} : 2'b00;
      o_done  <= (state_s == S_DONE) ? {win_r, ~win_r} : 2'b00;
      if (fill_nx_s) o_flash_addr <= (state_r == S_GRANT) ? sel_flash_s : flash_addr_r;
      else           o_flash_addr <= 24'd0;
      o_spram_we    <= accept_s;
      o_spram_addr  <= accept_s ? wptr_r : LEN_W'(0);
      o_spram_wdata <= accept_s ? i_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_spi_copy_sched.sv
// Directed bench for spi_copy_sched: single copy, zero length, contention,
// address wrap, drain timing and mid-transfer reset.
module tb_spi_copy_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  i_req;
  logic [23:0] i_flash_addr0, i_flash_addr1;
  logic [13:0] i_spram_addr0, i_spram_addr1, i_len0, i_len1;
  logic [1:0]  o_grant, o_done;
  logic        o_busy, o_fill;
  logic [23:0] o_flash_addr;
  logic        i_fifo_empty, i_word_en;
  logic [31:0] i_word;
  logic        o_spram_we;
  logic [13:0] o_spram_addr;
  logic [31:0] o_spram_wdata;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt0 = 0, done_cnt1 = 0, overlap_cnt = 0, fill_cnt = 0;
  logic [13:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  spi_copy_sched dut (
    .clk(clk), .reset(reset), .i_req(i_req),
    .i_flash_addr0(i_flash_addr0), .i_flash_addr1(i_flash_addr1),
    .i_spram_addr0(i_spram_addr0), .i_spram_addr1(i_spram_addr1),
    .i_len0(i_len0), .i_len1(i_len1),
    .o_grant(o_grant), .o_done(o_done), .o_busy(o_busy), .o_fill(o_fill),
    .o_flash_addr(o_flash_addr), .i_fifo_empty(i_fifo_empty),
    .i_word_en(i_word_en), .i_word(i_word), .o_spram_we(o_spram_we),
    .o_spram_addr(o_spram_addr), .o_spram_wdata(o_spram_wdata)
  );

  always #5 clk = ~clk;

  // Observe SPRAM writes and handshake events on the falling edge
  always @(negedge clk) begin
    if (o_spram_we === 1'b1) begin
      wr_addr_q.push_back(o_spram_addr);
      wr_data_q.push_back(o_spram_wdata);
    end
    if (o_done[0] === 1'b1) done_cnt0++;
    if (o_done[1] === 1'b1) done_cnt1++;
    if (o_grant === 2'b11) overlap_cnt++;
    if (o_fill === 1'b1) fill_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fill(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (o_fill === 1'b1) break;
      tick();
    end
    chk(tag, 64'(o_fill), 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 100; i++) begin
      if (o_done !== 2'b00) break;
      tick();
    end
    chk(tag, 64'(o_done), 64'(exp));
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      i_word_en = 1'b1;
      i_word    = base + 32'(i);
      tick();
    end
    i_word_en = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, 64'(o_grant), 64'd0);
    chk({tag, "_done"},  64'(o_done), 64'd0);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_fill"},  64'(o_fill), 64'd0);
    chk({tag, "_faddr"}, 64'(o_flash_addr), 64'd0);
    chk({tag, "_we"},    64'(o_spram_we), 64'd0);
    chk({tag, "_saddr"}, 64'(o_spram_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(o_spram_wdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [13:0] exp_addr [8];
    int          n;
    int          dc;
    int          fc;

    reset = 1'b1; i_req = 2'b00; i_word_en = 1'b0; i_word = 32'd0; i_fifo_empty = 1'b1;
    i_flash_addr0 = 24'd0; i_flash_addr1 = 24'd0;
    i_spram_addr0 = 14'd0; i_spram_addr1 = 14'd0; i_len0 = 14'd0; i_len1 = 14'd0;
    repeat (3) tick();
    chk_outputs_zero("rst");
    reset = 1'b0;
    tick();

    // Single copy of 4 words plus 3 prefetched extras
    i_flash_addr0 = 24'h010000; i_spram_addr0 = 14'h0100; i_len0 = 14'd4; i_req = 2'b01;
    wait_fill("t1_fill");
    chk("t1_grant", 64'(o_grant), 64'h1);
    chk("t1_faddr", 64'(o_flash_addr), 64'h010000);
    repeat (4) tick();
    feed(4, 32'hA000_0000);
    chk("t1_fill_low", 64'(o_fill), 64'd0);
    i_fifo_empty = 1'b0;
    feed(3, 32'hEEEE_0000);
    i_fifo_empty = 1'b1;
    wait_done("t1_done", 2'b01);
    i_req = 2'b00;
    chk("t1_nwr", 64'(wr_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_waddr", 64'(wr_addr_q[i]), 64'(14'h0100 + 14'(i)));
      chk("t1_wdata", 64'(wr_data_q[i]), 64'(32'hA000_0000 + 32'(i)));
    end
    tick();
    chk("t1_done_pulse", 64'(o_done), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt0), 64'd1);
    wr_addr_q.delete(); wr_data_q.delete();

    // Zero-length copy on requester 1
    i_flash_addr1 = 24'h0A0B0C; i_spram_addr1 = 14'h0010; i_len1 = 14'd0;
    fc = fill_cnt;
    i_req = 2'b10;
    tick();
    chk("t2_grant", 64'(o_grant), 64'h2);
    chk("t2_busy", 64'(o_busy), 64'd1);
    tick();
    chk("t2_done", 64'(o_done), 64'h2);
    chk("t2_grant_clr", 64'(o_grant), 64'd0);
    i_req = 2'b00;
    tick();
    chk("t2_idle", 64'(o_busy), 64'd0);
    chk("t2_no_fill", 64'(fill_cnt - fc), 64'd0);
    chk("t2_no_wr", 64'(wr_addr_q.size()), 64'd0);

    // Contention: both requesters continuously, grants alternate
    i_spram_addr0 = 14'h0200; i_len0 = 14'd2; i_spram_addr1 = 14'h0300; i_len1 = 14'd2;
    i_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_fill("t3_fill");
      chk("t3_order", 64'(o_grant), (t % 2 == 0) ? 64'h1 : 64'h2);
      repeat (4) tick();
      feed(2, 32'hC000_0000 + 32'(t * 16));
      wait_done("t3_done", (t % 2 == 0) ? 2'b01 : 2'b10);
    end
    i_req = 2'b00;
    tick();
    chk("t3_overlap", 64'(overlap_cnt), 64'd0);
    chk("t3_nwr", 64'(wr_addr_q.size()), 64'd8);
    exp_addr = '{14'h0200, 14'h0201, 14'h0300, 14'h0301, 14'h0200, 14'h0201, 14'h0300, 14'h0301};
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++)
      chk("t3_waddr", 64'(wr_addr_q[i]), 64'(exp_addr[i]));
    wr_addr_q.delete(); wr_data_q.delete();

    // SPRAM address wrap, with a stray word during START
    i_flash_addr0 = 24'h123456; i_spram_addr0 = 14'h3FFE; i_len0 = 14'd4; i_req = 2'b01;
    wait_fill("t4_fill");
    chk("t4_faddr", 64'(o_flash_addr), 64'h123456);
    i_word_en = 1'b1; i_word = 32'hDEAD_BEEF;
    tick();
    i_word_en = 1'b0;
    repeat (3) tick();
    feed(4, 32'h5000_0000);
    wait_done("t4_done", 2'b01);
    i_req = 2'b00;
    chk("t4_nwr", 64'(wr_addr_q.size()), 64'd4);
    exp_addr[0] = 14'h3FFE; exp_addr[1] = 14'h3FFF; exp_addr[2] = 14'h0000; exp_addr[3] = 14'h0001;
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk("t4_waddr", 64'(wr_addr_q[i]), 64'(exp_addr[i]));
      chk("t4_wdata", 64'(wr_data_q[i]), 64'(32'h5000_0000 + 32'(i)));
    end
    tick();
    wr_addr_q.delete(); wr_data_q.delete();

    // Drain: FIFO briefly non-empty every 10 cycles restarts the idle window
    i_spram_addr1 = 14'h0055; i_len1 = 14'd1; i_req = 2'b10;
    wait_fill("t5_fill");
    repeat (4) tick();
    feed(1, 32'h0000_0077);
    dc = done_cnt1;
    for (int k = 0; k < 3; k++) begin
      repeat (9) tick();
      i_fifo_empty = 1'b0;
      tick();
      i_fifo_empty = 1'b1;
    end
    chk("t5_no_early_done", 64'(done_cnt1 - dc), 64'd0);
    n = 0;
    while (n < 40 && o_done === 2'b00) begin
      tick();
      n++;
    end
    chk("t5_drain_cycles", 64'(n), 64'd16);
    chk("t5_done", 64'(o_done), 64'h2);
    i_req = 2'b00;
    chk("t5_nwr", 64'(wr_addr_q.size()), 64'd1);
    tick();
    wr_addr_q.delete(); wr_data_q.delete();

    // Reset on the second word of an 8-word copy, then a normal copy
    i_flash_addr0 = 24'h00ABCD; i_spram_addr0 = 14'h0040; i_len0 = 14'd8; i_req = 2'b01;
    wait_fill("t6_fill");
    repeat (4) tick();
    i_word_en = 1'b1; i_word = 32'h0000_0001;
    tick();
    i_word = 32'h0000_0002; reset = 1'b1;
    tick();
    chk_outputs_zero("t6_rst");
    reset = 1'b0; i_word_en = 1'b0; i_req = 2'b00;
    dc = done_cnt0;
    repeat (30) tick();
    chk("t6_no_done", 64'(done_cnt0 - dc), 64'd0);
    chk("t6_nwr", 64'(wr_addr_q.size()), 64'd1);
    wr_addr_q.delete(); wr_data_q.delete();
    i_spram_addr0 = 14'h0011; i_len0 = 14'd1; i_req = 2'b01;
    wait_fill("t6_fill2");
    chk("t6_grant2", 64'(o_grant), 64'h1);
    repeat (4) tick();
    feed(1, 32'h0000_0099);
    wait_done("t6_done2", 2'b01);
    i_req = 2'b00;
    chk("t6_nwr2", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() > 0) chk("t6_waddr2", 64'(wr_addr_q[0]), 64'h0011);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_copy_sched.md
Name: spi_copy_sched

Overview:
- Scheduler that shares the dual-output SPI flash read FIFO (spi_fifo) between two requesters, e.g. the boot loader and a runtime overlay loader.
- Each granted request is a flash-to-SPRAM copy: start flash byte address, SPRAM word address, length in 32-bit words.
- Block drives the FIFO's fill/address inputs, writes exactly the requested number of words to SPRAM, then drains FIFO prefetch so the next copy starts clean.

Parameters:
- LEN_W, 14, width of word count and SPRAM word address.
- FLUSH_CYC, 16, consecutive idle cycles (fifo empty, no word strobe) required to end DRAIN; must be >= 2.
- START_HOLD, 4, cycles fill is held high before any word is accepted.

Ports:
- clk  in  1  sole clock; same domain as the FIFO read side.
- reset  in  1  synchronous, active-high.
- i_req  in  2  per-requester level request; held until matching o_done pulse.
- i_flash_addr0 / i_flash_addr1  in  24  start flash byte address per requester.
- i_spram_addr0 / i_spram_addr1  in  LEN_W  start SPRAM word address per requester.
- i_len0 / i_len1  in  LEN_W  word count per requester; 0 is legal.
- o_grant  out  2  one-hot; high for the whole granted transfer.
- o_done  out  2  one-cycle pulse per requester at transfer end.
- o_busy  out  1  high whenever state != IDLE.
- o_fill  out  1  to FIFO fill input.
- o_flash_addr  out  24  to FIFO flash address; stable while o_fill high.
- i_fifo_empty  in  1  from FIFO.
- i_word_en  in  1  from FIFO SPRAM word strobe.
- i_word  in  32  from FIFO SPRAM word data.
- o_spram_we  out  1  SPRAM write enable.
- o_spram_addr  out  LEN_W  SPRAM word address.
- o_spram_wdata  out  32  SPRAM write data.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer selects requester 0 first.
- Reset mid-transfer: same values next cycle. o_fill drops immediately. The transfer is abandoned with no o_done.
- IDLE: if any i_req is high, go to GRANT. The winner is the requester at the pointer if it is requesting, else the other one.
- Round-robin pointer: after each grant it moves to the non-granted requester. With both requesting continuously, grants alternate 0,1,0,1.
- GRANT (1 cycle): latch flash addr, SPRAM addr and len of the winner; assert o_grant. If len == 0, go to DONE without asserting o_fill. Otherwise go to START.
- START: o_fill = 1 and o_flash_addr = latched address. Hold START_HOLD cycles, then go to RUN. Any i_word_en seen in START is an error case: discard the word and do not count it.
- RUN: each i_word_en registers one write on the next cycle: o_spram_we = 1, o_spram_addr = current pointer, o_spram_wdata = i_word.
  - Pointer increments after each write and wraps modulo 2^LEN_W.
  - Remaining count decrements per accepted word.
  - On the cycle the last word is accepted (remaining == 1 and i_word_en), go to DRAIN; o_fill is 0 from that next cycle on.
- DRAIN: o_fill = 0. Words arriving here are discarded: no o_spram_we, no count change. An idle counter increments on cycles with i_fifo_empty = 1 and i_word_en = 0, and clears otherwise. At FLUSH_CYC go to DONE.
- DONE (1 cycle): pulse o_done for the granted requester; clear o_grant; go to IDLE. The earliest next grant is 2 cycles after DONE (IDLE, GRANT).
- o_spram_we is never asserted outside RUN+1 cycle. The total number of writes per transfer equals the latched len exactly.
- i_req deasserted mid-transfer: ignored; the transfer completes and o_done still pulses.
- Input address/len changes after GRANT: ignored.
- A new i_req during a transfer waits; arbitration happens only in IDLE.

Test Plan:
- Single copy: req0, flash 0x010000, spram 0x0100, len 4. Model supplies 4 words then 3 extra -> exactly 4 writes at 0x0100-0x0103, extras discarded, o_fill low after word 4, o_done[0] single pulse.
- Zero length: req1 with len 0 -> o_fill never high, no writes, o_done[1] 2 cycles after grant.
- Contention: req0 and req1 both high continuously, len 2 each -> grant order 0,1,0,1. No overlap of o_grant bits.
- Wrap: spram 0x3FFE, len 4, LEN_W=14 -> writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Drain: after last word, model toggles i_fifo_empty low every 10 cycles three times -> DONE only after 16 consecutive idle cycles. No writes during drain.
- Reset at word 2 of len 8 -> next cycle all outputs 0, no o_done. A subsequent req0 is granted normally.
